cl_divider: RTL and testbench
=============================

Name: cl_divider

Overview:
- Sequential carry-less (GF(2)[x]) long divider: the inverse of the carry-less multiplier.
- Takes a 2*DATA_WIDTH-bit dividend, typically a carry-less product, and an DATA_WIDTH-bit divisor.
- Produces quotient and remainder, one dividend bit per clock.
- Sits beside the carry-less adder/multiplier/exponent unit under top; used for product reduction and for checking multiplier results.

Parameters:
- DATA_WIDTH, 32, divisor/remainder width; dividend and quotient are 2*DATA_WIDTH.
- CNT_WIDTH, $clog2(2*DATA_WIDTH), width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- a  in  2*DATA_WIDTH  dividend, sampled on the accepting edge
- b  in  DATA_WIDTH  divisor, sampled on the accepting edge
- busy  out  1  high in RUN and DONE
- out_valid  out  1  results valid; held until consumed
- out_ready  in  1  consumer accepts the result
- quotient  out  2*DATA_WIDTH  a div b over GF(2)
- remainder  out  DATA_WIDTH  a mod b over GF(2); degree < deg(b)
- div_by_zero  out  1  b was 0; qualified by out_valid

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE; busy, out_valid, div_by_zero, quotient and remainder all 0; internal registers cleared.
- Reset mid-operation aborts the operation with no output.
- IDLE, start=1 at edge k:
  - latch a and b;
  - d = index of the highest set bit of b;
  - r=0, q=0, cnt=2*DATA_WIDTH-1;
  - go to RUN.
- IDLE with b==0 at the accepting edge: go directly to DONE with div_by_zero=1, quotient=0, remainder=0. out_valid is high after edge k.
- RUN, each edge:
  - t = {r[DATA_WIDTH-2:0], a_reg[cnt]};
  - qbit = t[d];
  - r = qbit ? t ^ b_reg : t;
  - q[cnt] = qbit;
  - cnt decrements.
- RUN, edge with cnt==0: go to DONE.
- Latency: out_valid rises after edge k+2*DATA_WIDTH (64 for default), independent of operand values.
- Width rule: t is DATA_WIDTH bits.
  - For d = DATA_WIDTH-1, the top bit of t is the shifted-in r[DATA_WIDTH-2]; r always has degree < d, so no overflow.
  - For d=0 (b==1): quotient=a, remainder=0.
- DONE: out_valid=1; quotient, remainder and div_by_zero held stable.
  - out_ready=1 at an edge: go to IDLE, out_valid=0. Outputs keep their last value.
- start is ignored in RUN and DONE.
- start and out_ready high on the same DONE edge: return to IDLE only. The new start must be presented again (no back-to-back acceptance).
- Invariant: clmul(quotient, b) ^ remainder == a.

Decomposition:
- Shared gf_pkg: DATA_WIDTH default and the state enum {IDLE, RUN, DONE}. The carry-less multiplier unit reuses it.
- One natural sub-module: gf_degree (priority encoder, DATA_WIDTH in, $clog2(DATA_WIDTH) out, returns the index of the highest set bit; 0 when input is 0). Instantiated once for b.
- Datapath and FSM stay in cl_divider.

Test Plan:
- Reset with resetn=0 for 2 cycles mid-RUN:
  - all outputs 0 and state IDLE on the next edge;
  - a new start then completes normally.
- a=120, b=10 (the product 12 clmul 10) -> quotient=12, remainder=0, div_by_zero=0. out_valid exactly 64 cycles after the start edge.
- a=1348, b=78 (22 clmul 78) -> quotient=22, remainder=0. a=13, b=3 -> quotient=4, remainder=1.
- a=32'hDEADBEEF, b=1 -> quotient=32'hDEADBEEF, remainder=0. a=any, b=0 -> div_by_zero=1, quotient=0, remainder=0, out_valid 1 cycle after start.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, busy=1. start pulses during RUN/DONE are ignored. Pulsing out_ready returns to IDLE.
- Random: 1000 random (a, b≠0) pairs -> check clmul(quotient, b)^remainder==a and that the degree of remainder < the degree of b.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared definitions for the carry-less arithmetic units (adder, multiplier, divider).
package gf_pkg;

    localparam int GF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_e;

endpackage

// File: rtl/gf_degree.sv
// Priority encoder: index of the highest set bit of i_val, 0 when i_val is zero.
module gf_degree #(
    parameter int WIDTH     = 32,
    parameter int DEG_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     i_val,
    output logic [DEG_WIDTH-1:0] o_deg
);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        o_deg = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_deg = i_val[i] ? DEG_WIDTH'(i) : o_deg;
        end
    end

endmodule

// File: rtl/cl_divider.sv
// Sequential GF(2)[x] long divider: one dividend bit per clock, quotient and remainder
// held in DONE until the consumer accepts them.
module cl_divider
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = GF_DATA_WIDTH,
    parameter int CNT_WIDTH  = $clog2(2*DATA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [2*DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   quotient,
    output logic [DATA_WIDTH-1:0]     remainder,
    output logic                      div_by_zero
);

    localparam int QW        = 2*DATA_WIDTH;
    localparam int DEG_WIDTH = $clog2(DATA_WIDTH);

    gf_state_e             r_state;
    gf_state_e             w_state_next;
    logic [QW-1:0]         r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DEG_WIDTH-1:0]  r_d;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [QW-1:0]         r_q;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [QW-1:0]         r_quotient;
    logic [DATA_WIDTH-1:0] r_remainder;
    logic                  r_dbz;
    logic                  r_busy;
    logic                  r_out_valid;

    logic [DEG_WIDTH-1:0]  w_deg;
    logic [DATA_WIDTH-1:0] w_t;
    logic                  w_qbit;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [QW-1:0]         w_q_next;

    gf_degree #(
        .WIDTH     (DATA_WIDTH),
        .DEG_WIDTH (DEG_WIDTH)
    ) u_deg_b (
        .i_val (b),
        .o_deg (w_deg)
    );

    // One reduction step: r has degree < d, so t never exceeds degree d and fits DATA_WIDTH bits.
    always_comb begin
        w_t        = {r_rem[DATA_WIDTH-2:0], r_a[r_cnt]};
        w_qbit     = w_t[r_d];
        w_rem_next = w_qbit ? (w_t ^ r_b) : w_t;
        w_q_next   = r_q | (QW'(w_qbit) << r_cnt);
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (b == '0) ? DONE : RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_busy      <= (w_state_next != IDLE);
            r_out_valid <= (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_d   <= w_deg;
                        r_rem <= '0;
                        r_q   <= '0;
                        r_cnt <= CNT_WIDTH'(QW-1);
                        if (b == '0) begin
                            r_quotient  <= '0;
                            r_remainder <= '0;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CNT_WIDTH'(1);
                    if (r_cnt == '0) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next;
                        r_dbz       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_cl_divider.sv
// Scoreboard bench for cl_divider: fixed vectors, reset abort, backpressure, random pairs.
module tb_cl_divider;

    localparam int DW = 32;
    localparam int QW = 64;

    typedef struct {
        logic [QW-1:0] a;
        logic [DW-1:0] b;
        logic [QW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [QW-1:0] a_i;
    logic [DW-1:0] b_i;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    cl_divider #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .a           (a_i),
        .b           (b_i),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    function automatic int deg_of(input logic [QW-1:0] v);
        int d = -1;
        for (int i = 0; i < QW; i++) if (v[i]) d = i;
        return d;
    endfunction

    // Reference: textbook polynomial long division on the whole dividend.
    function automatic exp_t ref_div(input logic [QW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        logic [QW-1:0] rem;
        logic [QW-1:0] bw;
        int db;
        e.a = a; e.b = b; e.q = '0; e.r = '0; e.dbz = 1'b0;
        if (b == '0) begin
            e.dbz = 1'b1;
            return e;
        end
        db  = deg_of({32'd0, b});
        rem = a;
        bw  = {32'd0, b};
        for (int i = QW-1; i >= db; i--) begin
            if (rem[i]) begin
                e.q[i-db] = 1'b1;
                rem = rem ^ (bw << (i-db));
            end
        end
        e.r = rem[DW-1:0];
        return e;
    endfunction

    function automatic logic [2*QW-1:0] clmul(input logic [QW-1:0] x, input logic [DW-1:0] y);
        logic [2*QW-1:0] acc = '0;
        for (int i = 0; i < DW; i++) if (y[i]) acc = acc ^ ({64'd0, x} << i);
        return acc;
    endfunction

    // Pulse start for one edge and record the expected result; returns just after edge k.
    task automatic issue(input exp_t e);
        a_i = e.a; b_i = e.b; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Bounded wait for out_valid; lat = edges elapsed, -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (quotient !== 64'd0) $display("FAIL reset_q got %h exp 0", quotient); else n_pass++;
        n_checks++; if (remainder !== 32'd0) $display("FAIL reset_r got %h exp 0", remainder); else n_pass++;
        n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b exp 0", div_by_zero); else n_pass++;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        exp_t vec[5];
        exp_t e;
        int lat;
        vec[0] = '{a:64'd120,          b:32'd10, q:64'd12,          r:32'd0, dbz:1'b0};
        vec[1] = '{a:64'd1348,         b:32'd78, q:64'd22,          r:32'd0, dbz:1'b0};
        vec[2] = '{a:64'd13,           b:32'd3,  q:64'd4,           r:32'd1, dbz:1'b0};
        vec[3] = '{a:64'hDEADBEEF,     b:32'd1,  q:64'hDEADBEEF,    r:32'd0, dbz:1'b0};
        vec[4] = '{a:64'h1234_5678_9ABC, b:32'd0, q:64'd0,          r:32'd0, dbz:1'b1};
        for (int i = 0; i < 5; i++) begin
            issue(vec[i]);
            wait_valid(lat);
            e = sb.pop_front();
            n_checks++;
            if (lat !== (e.dbz ? 0 : 64)) $display("FAIL known%0d_latency got %0d exp %0d", i, lat, e.dbz ? 0 : 64); else n_pass++;
            n_checks++; if (quotient !== e.q) $display("FAIL known%0d_q got %h exp %h", i, quotient, e.q); else n_pass++;
            n_checks++; if (remainder !== e.r) $display("FAIL known%0d_r got %h exp %h", i, remainder, e.r); else n_pass++;
            n_checks++; if (div_by_zero !== e.dbz) $display("FAIL known%0d_dbz got %b exp %b", i, div_by_zero, e.dbz); else n_pass++;
            n_checks++; if (busy !== 1'b1) $display("FAIL known%0d_busy got %b exp 1", i, busy); else n_pass++;
            consume();
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL known%0d_release got valid=%b busy=%b exp 0/0", i, out_valid, busy); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int lat;
        issue('{a:64'd120, b:32'd10, q:64'd12, r:32'd0, dbz:1'b0});
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || quotient !== 64'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0)
            $display("FAIL midreset_outputs got busy=%b valid=%b q=%h r=%h dbz=%b exp all 0", busy, out_valid, quotient, remainder, div_by_zero);
        else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_idle got valid=%b busy=%b exp 0/0", out_valid, busy); else n_pass++;
        issue('{a:64'd13, b:32'd3, q:64'd4, r:32'd1, dbz:1'b0});
        wait_valid(lat);
        e = sb.pop_front();
        n_checks++; if (lat !== 64) $display("FAIL midreset_latency got %0d exp 64", lat); else n_pass++;
        n_checks++; if (quotient !== e.q || remainder !== e.r) $display("FAIL midreset_result got q=%h r=%h exp q=%h r=%h", quotient, remainder, e.q, e.r); else n_pass++;
        consume();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        issue('{a:64'd1348, b:32'd78, q:64'd22, r:32'd0, dbz:1'b0});
        for (int i = 0; i < 10; i++) begin
            a_i = 64'd99; b_i = 32'd0; start = i[0];
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_valid(lat);
        e = sb.pop_front();
        n_checks++; if (lat + 10 !== 64) $display("FAIL bp_latency got %0d exp 64", lat + 10); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            start = ~i[0]; a_i = 64'd7; b_i = 32'd0;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0)
                $display("FAIL bp_hold%0d got valid=%b busy=%b q=%h r=%h dbz=%b exp 1/1 q=%h r=%h dbz=0", i, out_valid, busy, quotient, remainder, div_by_zero, e.q, e.r);
            else n_pass++;
        end
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release got valid=%b busy=%b exp 0/0", out_valid, busy); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_no_b2b got busy=%b exp 0", busy); else n_pass++;
        n_checks++; if (quotient !== e.q) $display("FAIL bp_keep_q got %h exp %h", quotient, e.q); else n_pass++;
    endtask

    task automatic test_random();
        exp_t e;
        exp_t got;
        logic [QW-1:0] ra;
        logic [DW-1:0] rb;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == '0) rb = 32'd1;
            issue(ref_div(ra, rb));
            wait_valid(lat);
            got = sb.pop_front();
            n_checks++; if (lat !== 64) $display("FAIL rand%0d_latency got %0d exp 64", i, lat); else n_pass++;
            n_checks++;
            if (quotient !== got.q || remainder !== got.r)
                $display("FAIL rand%0d_result a=%h b=%h got q=%h r=%h exp q=%h r=%h", i, got.a, got.b, quotient, remainder, got.q, got.r);
            else n_pass++;
            n_checks++;
            if ((clmul(quotient, got.b) ^ {96'd0, remainder}) !== {64'd0, got.a})
                $display("FAIL rand%0d_invariant got %h exp %h", i, clmul(quotient, got.b) ^ {96'd0, remainder}, got.a);
            else n_pass++;
            n_checks++;
            if (deg_of({32'd0, remainder}) >= deg_of({32'd0, got.b}) && remainder !== 32'd0)
                $display("FAIL rand%0d_degree got %0d exp < %0d", i, deg_of({32'd0, remainder}), deg_of({32'd0, got.b}));
            else n_pass++;
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_mid_reset();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
